// File: rtl/gp_core_pkg.sv
// Shared GP-Core types: hazard shadow entries and forward-source encodings.
package gp_core_pkg;

    localparam int NUM_REGS_DEF   = 8;
    localparam int DEPTH_DEF      = 4;
    localparam int LOAD_READY_DEF = 3;
    localparam int HAZ_RD_W       = 8;

    typedef struct packed {
        logic                valid;
        logic [HAZ_RD_W-1:0] rd;
        logic                wr;
        logic                ld;
    } haz_entry_t;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM1 = 2'd1,
        FWD_MEM2 = 2'd2,
        FWD_WB   = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/gp_fwd_match.sv
// Nearest-producer search for one source operand against the hazard shadow.
module gp_fwd_match
    import gp_core_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LOAD_READY = LOAD_READY_DEF,
    parameter int REG_W      = 3,
    parameter int SEL_W      = 2
) (
    input  haz_entry_t [DEPTH-1:0] sh_i,
    input  logic [REG_W-1:0]       src_i,
    input  logic                   used_i,
    output logic                   hit_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   lu_o
);

    logic [HAZ_RD_W-1:0] src_ext;

    assign src_ext = HAZ_RD_W'(src_i);

    // Oldest first so the nearest producer overwrites; stage DEPTH-1 reads the write-through RF.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        lu_o  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used_i && sh_i[k].valid && sh_i[k].wr && (sh_i[k].rd == src_ext)) begin
                hit_o = 1'b1;
                if (k == DEPTH - 1) begin
                    sel_o = '0;
                    lu_o  = 1'b0;
                end else if (sh_i[k].ld && ((k + 1) < LOAD_READY)) begin
                    sel_o = '0;
                    lu_o  = 1'b1;
                end else begin
                    sel_o = SEL_W'(k + 1);
                    lu_o  = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/gp_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, flush and freeze.
// Define GP_HAZ_PERF_EN to build the saturating stall/flush counters.
module gp_hazard_ctrl
    import gp_core_pkg::*;
#(
    parameter int  NUM_REGS   = NUM_REGS_DEF,
    parameter int  DEPTH      = DEPTH_DEF,
    parameter int  LOAD_READY = LOAD_READY_DEF,
    parameter int  CNT_W      = 32,
    localparam int REG_W      = $clog2(NUM_REGS),
    localparam int SEL_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             icache_ready,
    input  logic             dcache_stall,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_write,
    output logic             if_flush,
    output logic             id_bubble,
    output logic             back_en,
    output logic [SEL_W-1:0] ex_fwd_a,
    output logic [SEL_W-1:0] ex_fwd_b,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    haz_entry_t [DEPTH-1:0] sh_q, sh_d;
    haz_entry_t             id_ent;
    logic [SEL_W-1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [SEL_W-1:0]       sel_a, sel_b;
    logic                   hit_a, hit_b, lu_a, lu_b;
    logic                   lu_stall, lu_bubble, flush_cyc;

    gp_fwd_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_W(REG_W), .SEL_W(SEL_W)
    ) u_match_a (
        .sh_i(sh_q), .src_i(id_rs1), .used_i(id_rs1_used),
        .hit_o(hit_a), .sel_o(sel_a), .lu_o(lu_a)
    );

    gp_fwd_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .REG_W(REG_W), .SEL_W(SEL_W)
    ) u_match_b (
        .sh_i(sh_q), .src_i(id_rs2), .used_i(id_rs2_used),
        .hit_o(hit_b), .sel_o(sel_b), .lu_o(lu_b)
    );

    assign lu_stall = (lu_a | lu_b) & id_valid;

    always_comb begin
        id_ent.valid = id_valid;
        id_ent.rd    = HAZ_RD_W'(id_rd);
        id_ent.wr    = id_reg_write & id_valid;
        id_ent.ld    = id_mem_read & id_valid;
    end

    always_comb begin
        pc_write  = 1'b1;
        if_write  = 1'b1;
        if_flush  = 1'b0;
        id_bubble = 1'b0;
        back_en   = 1'b1;
        lu_bubble = 1'b0;
        flush_cyc = 1'b0;
        fwd_a_d   = hit_a ? sel_a : '0;
        fwd_b_d   = hit_b ? sel_b : '0;
        sh_d      = sh_q;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            sh_d[k] = sh_q[k-1];
        end
        sh_d[0] = id_ent;
        if (dcache_stall) begin
            // EX is frozen and will re-present any branch once released.
            back_en  = 1'b0;
            pc_write = 1'b0;
            if_write = 1'b0;
            sh_d     = sh_q;
            fwd_a_d  = fwd_a_q;
            fwd_b_d  = fwd_b_q;
        end else if (branch_taken) begin
            if_flush  = 1'b1;
            id_bubble = 1'b1;
            flush_cyc = 1'b1;
            sh_d[0]   = '0;
            fwd_a_d   = '0;
            fwd_b_d   = '0;
        end else if (lu_stall) begin
            pc_write  = 1'b0;
            if_write  = 1'b0;
            id_bubble = 1'b1;
            lu_bubble = 1'b1;
            sh_d[0]   = '0;
            fwd_a_d   = '0;
            fwd_b_d   = '0;
        end else if (!icache_ready) begin
            pc_write = 1'b0;
            if_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            sh_q    <= sh_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign ex_fwd_a = fwd_a_q;
    assign ex_fwd_b = fwd_b_q;

`ifdef GP_HAZ_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (lu_bubble && !(&lu_cnt_q)) begin
            lu_cnt_d = lu_cnt_q + 1'b1;
        end
        if (flush_cyc && !(&fl_cnt_q)) begin
            fl_cnt_d = fl_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign perf_lu_cnt    = lu_cnt_q;
    assign perf_flush_cnt = fl_cnt_q;
`else
    logic perf_unused;

    assign perf_unused    = lu_bubble ^ flush_cyc;
    assign perf_lu_cnt    = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_gp_hazard_ctrl.sv
// Directed bench for gp_hazard_ctrl at default parameters (8 regs, depth 4, load-ready 3).
module tb_gp_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        id_reg_write, id_mem_read;
    logic        icache_ready, dcache_stall, branch_taken;
    logic        pc_write, if_write, if_flush, id_bubble, back_en;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic [31:0] perf_lu_cnt, perf_flush_cnt;

    int vecs = 0;
    int errs = 0;

    gp_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .icache_ready(icache_ready), .dcache_stall(dcache_stall),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .if_write(if_write), .if_flush(if_flush),
        .id_bubble(id_bubble), .back_en(back_en),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .perf_lu_cnt(perf_lu_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_reg_write = 0; id_mem_read = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic instr(input logic [2:0] rd, input logic wr, input logic ld,
                         input logic [2:0] r1, input logic u1,
                         input logic [2:0] r2, input logic u2);
        id_valid = 1; id_rd = rd; id_reg_write = wr; id_mem_read = ld;
        id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) step();
    endtask

    initial begin
        rst_n = 0; icache_ready = 1; dcache_stall = 0; branch_taken = 0;
        idle();
        #12;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_back_en", back_en, 1);
        chk("rst_if_flush", if_flush, 0);
        chk("rst_id_bubble", id_bubble, 0);
        chk("rst_fwd_a", ex_fwd_a, 0);
        chk("rst_fwd_b", ex_fwd_b, 0);
        chk("rst_perf_lu", perf_lu_cnt, 0);
        rst_n = 1;
        repeat (2) step();
        chk("idle_pc_write", pc_write, 1);
        chk("idle_if_write", if_write, 1);
        chk("idle_fwd_a", ex_fwd_a, 0);

        // ADD r2 ; SUB r3 = r2 - r1
        instr(3'd2, 1, 0, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd3, 1, 0, 3'd2, 1, 3'd1, 1);
        chk("raw_no_bubble", id_bubble, 0);
        chk("raw_pc_write", pc_write, 1);
        step();
        chk("raw_fwd_a", ex_fwd_a, 1);
        chk("raw_fwd_b", ex_fwd_b, 0);
        drain();

        // LOAD r4 ; ADD r5 = r4 : two bubbles then select 3
        instr(3'd4, 1, 1, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd5, 1, 0, 3'd4, 1, 3'd0, 0);
        chk("lu1_bubble", id_bubble, 1);
        chk("lu1_pc_write", pc_write, 0);
        chk("lu1_if_write", if_write, 0);
        step();
        chk("lu2_bubble", id_bubble, 1);
        chk("lu2_pc_write", pc_write, 0);
        chk("lu2_fwd_a", ex_fwd_a, 0);
        step();
        chk("lu3_bubble", id_bubble, 0);
        chk("lu3_pc_write", pc_write, 1);
        step();
        chk("lu_fwd_a", ex_fwd_a, 3);
        drain();

        // Load-use with branch taken on the first stall cycle
        instr(3'd4, 1, 1, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd5, 1, 0, 3'd4, 1, 3'd0, 0);
        branch_taken = 1; #1;
        chk("br_if_flush", if_flush, 1);
        chk("br_id_bubble", id_bubble, 1);
        chk("br_pc_write", pc_write, 1);
        step();
        branch_taken = 0;
        idle(); #1;
        chk("br_fwd_a", ex_fwd_a, 0);
        chk("br_no_stall", id_bubble, 0);
`ifdef GP_HAZ_PERF_EN
        chk("br_perf_flush", perf_flush_cnt, 1);
        chk("br_perf_lu", perf_lu_cnt, 2);
`else
        chk("br_perf_flush", perf_flush_cnt, 0);
        chk("br_perf_lu", perf_lu_cnt, 0);
`endif
        drain();

        // dcache freeze with forwards pending
        instr(3'd2, 1, 0, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd3, 1, 0, 3'd2, 1, 3'd1, 1);
        step();
        instr(3'd6, 1, 0, 3'd3, 1, 3'd2, 1);
        dcache_stall = 1; branch_taken = 1; #1;
        for (int i = 0; i < 5; i++) begin
            chk("frz_back_en", back_en, 0);
            chk("frz_pc_write", pc_write, 0);
            chk("frz_if_write", if_write, 0);
            chk("frz_if_flush", if_flush, 0);
            chk("frz_fwd_a", ex_fwd_a, 1);
            step();
        end
        dcache_stall = 0; branch_taken = 0; #1;
        chk("rel_back_en", back_en, 1);
        step();
        chk("rel_fwd_a", ex_fwd_a, 1);
        chk("rel_fwd_b", ex_fwd_b, 2);
        drain();

        // Two writers of r5: nearest wins
        instr(3'd5, 1, 0, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd6, 1, 0, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd5, 1, 0, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd1, 1, 0, 3'd5, 1, 3'd6, 1);
        step();
        chk("near_fwd_a", ex_fwd_a, 1);
        chk("near_fwd_b", ex_fwd_b, 2);

        // Reset while a load-use stall is pending
        instr(3'd7, 1, 1, 3'd0, 0, 3'd0, 0);
        step();
        instr(3'd1, 1, 0, 3'd7, 1, 3'd0, 0);
        chk("pre_rst_bubble", id_bubble, 1);
        rst_n = 0; #1;
        chk("mid_rst_fwd_a", ex_fwd_a, 0);
        chk("mid_rst_fwd_b", ex_fwd_b, 0);
        chk("mid_rst_bubble", id_bubble, 0);
        chk("mid_rst_pc_write", pc_write, 1);
        chk("mid_rst_perf_flush", perf_flush_cnt, 0);
        step();
        rst_n = 1; #1;
        chk("post_rst_bubble", id_bubble, 0);
        step();
        chk("post_rst_fwd_a", ex_fwd_a, 0);
        chk("post_rst_pc_write", pc_write, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
